// File: rtl/imm_operand_encoder.sv
// imm_operand_encoder
//   Finds the encoding of a 32-bit constant as a second operand.
//   - mem_type=0: searches for a data-processing immediate {rot[3:0], imm8}
//     such that value == imm8 ROR (2*rot). One rot candidate is tested per
//     clock, and the lowest matching rot is reported (canonical form).
//   - mem_type=1: checks that value fits a signed MEM_OFFSET_W offset. This
//     is decided in a single step.
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   start             request input, sampled only while ready=1
//   value, mem_type   operand inputs, captured when start is accepted
//   ready             high only in IDLE
//   valid             one-cycle result strobe
//   found             high if an encoding exists; held until the next accepted start
//   operand_out       the encoding (zero when found=0); held until the next accepted start
module imm_operand_encoder #(
  parameter int ROT_STEPS    = 16,  // must be <= 16 (rot is a 4-bit field)
  parameter int MEM_OFFSET_W = 12   // must be <= 12 (operand_out width)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        mem_type,
  output logic        ready,
  output logic        valid,
  output logic        found,
  output logic [11:0] operand_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DONE} state_t;

  localparam logic [3:0] ROT_LAST = 4'(ROT_STEPS - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_value;
  logic [3:0]  r_rot;
  logic        r_found;
  logic [11:0] r_operand;

  logic        w_accept;
  logic [4:0]  w_shamt;
  logic [63:0] w_dbl;
  logic [31:0] w_cand;
  logic        w_match;
  logic        w_mem_ok;
  logic [11:0] w_mem_off;

  assign w_accept = (r_state == ST_IDLE) && start;

  // The upper half of the doubled word shifted left gives a 32-bit rotate-left.
  // A shift of 0 leaves the upper half equal to the original value.
  assign w_shamt = {r_rot, 1'b0};
  assign w_dbl   = {r_value, r_value} << w_shamt;
  assign w_cand  = w_dbl[63:32];
  assign w_match = (w_cand[31:8] == 24'd0);

  // The offset is representable if every bit from the sign bit upward is a
  // copy of that sign bit.
  assign w_mem_ok  = (&value[31:MEM_OFFSET_W-1]) | ~(|value[31:MEM_OFFSET_W-1]);
  assign w_mem_off = 12'(value[MEM_OFFSET_W-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    valid       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_state_nxt = mem_type ? ST_DONE : ST_SEARCH;
      end
      ST_SEARCH: begin
        if (w_match || (r_rot == ROT_LAST)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        valid       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value   <= '0;
      r_rot     <= '0;
      r_found   <= 1'b0;
      r_operand <= '0;
    end else if (w_accept) begin
      r_value <= value;
      r_rot   <= '0;
      if (mem_type) begin
        r_found   <= w_mem_ok;
        r_operand <= w_mem_ok ? w_mem_off : 12'h000;
      end else begin
        // The previous result is dropped as soon as a new search begins.
        r_found   <= 1'b0;
        r_operand <= 12'h000;
      end
    end else if (r_state == ST_SEARCH) begin
      if (w_match) begin
        r_found   <= 1'b1;
        r_operand <= {r_rot, w_cand[7:0]};
      end else if (r_rot == ROT_LAST) begin
        r_found   <= 1'b0;
        r_operand <= 12'h000;
      end else begin
        r_rot <= r_rot + 4'd1;
      end
    end
  end

  assign found       = r_found;
  assign operand_out = r_operand;

endmodule

// File: tb/tb_imm_operand_encoder.sv
module tb_imm_operand_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  logic        mem_type = 1'b0;
  logic        ready, valid, found;
  logic [11:0] operand_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_operand_encoder #(.ROT_STEPS(16), .MEM_OFFSET_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .mem_type(mem_type),
    .ready(ready), .valid(valid), .found(found), .operand_out(operand_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // imm8 ROR s, computed as a rotate in the decode direction.
  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    logic [63:0] d;
    d = {x, x} >> s;
    return d[31:0];
  endfunction

  // Reference answer: does any (rot, imm8) pair decode to v?
  function automatic logic encodable(input logic [31:0] v);
    for (int r = 0; r < 16; r++)
      for (int b = 0; b < 256; b += 1)
        if (ror32(32'(b), 2 * r) == v) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one request from IDLE and report the cycle (after the accepting edge) of valid.
  task automatic issue(input logic [31:0] v, input logic m,
                       output int cyc, output logic f, output logic [11:0] op);
    @(negedge clk);
    value = v; mem_type = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 32'hDEAD_BEEF;  // changes after capture must not matter
    mem_type = ~m;
    cyc = -1; f = 1'b0; op = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (valid) begin
        cyc = c; f = found; op = operand_out;
        break;
      end
    end
  endtask

  task automatic directed(input string tag, input logic [31:0] v, input logic m,
                          input int exp_cyc, input logic exp_f, input logic [11:0] exp_op);
    int cyc; logic f; logic [11:0] op;
    issue(v, m, cyc, f, op);
    chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_found"}, 32'(f), 32'(exp_f));
    chk({tag, "_op"}, 32'(op), 32'(exp_op));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(valid), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_held"}, 32'(operand_out), 32'(exp_op));
  endtask

  initial begin
    int cyc, nv; logic f; logic [11:0] op; logic [31:0] v;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_op", 32'(operand_out), 32'd0);
    rst = 1'b0;

    directed("imm_ff",    32'h0000_00FF, 1'b0, 2,  1'b1, 12'h0FF);
    directed("imm_ff24",  32'hFF00_0000, 1'b0, 6,  1'b1, 12'h4FF);
    directed("imm_3fc",   32'h0000_03FC, 1'b0, 17, 1'b1, 12'hFFF);
    directed("imm_102",   32'h0000_0102, 1'b0, 17, 1'b0, 12'h000);
    directed("imm_zero",  32'h0000_0000, 1'b0, 2,  1'b1, 12'h000);
    directed("imm_wrap",  32'hF000_000F, 1'b0, 4,  1'b1, 12'h2FF);
    directed("mem_neg",   32'hFFFF_F800, 1'b1, 1,  1'b1, 12'h800);
    directed("mem_ovf",   32'h0000_0800, 1'b1, 1,  1'b0, 12'h000);
    directed("mem_pos",   32'h0000_07FF, 1'b1, 1,  1'b1, 12'h7FF);
    directed("mem_ovfn",  32'hFFFF_F7FF, 1'b1, 1,  1'b0, 12'h000);

    // start held high through a search; new value offered mid-search is ignored
    @(negedge clk);
    value = 32'h0000_3FC0; mem_type = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 value = 32'h0000_00FF;
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (valid) begin
        cyc = c; f = found; op = operand_out;
        start = 1'b0;  // dropped in DONE, so the held start is never re-accepted
        break;
      end
    end
    chk("hold_cycle", 32'(cyc), 32'd15);
    chk("hold_found", 32'(f), 32'd1);
    chk("hold_op", 32'(op), 32'hDFF);
    start = 1'b0;
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("hold_extra_valid", 32'(nv), 32'd0);
    chk("hold_found_kept", 32'(found), 32'd1);

    // reset mid-search
    @(negedge clk);
    value = 32'h0000_0102; mem_type = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_busy", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(valid), 32'd0);
    chk("rst_mid_found", 32'(found), 32'd0);
    chk("rst_mid_op", 32'(operand_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("rst_mid_novalid", 32'(nv), 32'd0);

    // cross-check against decode: half constructed encodable values, half random
    for (int i = 0; i < 1200; i++) begin
      if (i % 2 == 0) v = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
      else            v = $urandom;
      issue(v, 1'b0, cyc, f, op);
      if (cyc < 0) begin
        chk("rnd_timeout", 32'(cyc), 32'd0);
      end else begin
        chk("rnd_found", 32'(f), 32'(encodable(v)));
        if (f) chk("rnd_decode", ror32(32'(op[7:0]), 2 * int'(op[11:8])), v);
        else   chk("rnd_zero_op", 32'(op), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
